// File: rtl/reg_ctrl_pkg.sv
// Shared encodings for the 16-bit register write port and its loaders.
// Also holds the low-write decode used by the byte loader.
package reg_ctrl_pkg;

    typedef enum logic [2:0] {
        FS_DEC    = 3'b000,
        FS_INC    = 3'b001,
        FS_LOAD   = 3'b010,
        FS_CLR    = 3'b011,
        FS_LOADLZ = 3'b100,
        FS_WRLO   = 3'b101,
        FS_WRHI   = 3'b110,
        FS_LOADSX = 3'b111
    } funsel_e;

    typedef enum logic [1:0] {
        CMD_LOAD16 = 2'b00,
        CMD_LOAD8Z = 2'b01,
        CMD_LOAD8S = 2'b10,
        CMD_CLEAR  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_WRITE_LO = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_WRITE_HI = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    function automatic funsel_e lo_funsel(cmd_e c);
        funsel_e fs;
        unique case (c)
            CMD_LOAD16: fs = FS_WRLO;
            CMD_LOAD8Z: fs = FS_LOADLZ;
            CMD_LOAD8S: fs = FS_LOADSX;
            default:    fs = FS_CLR;
        endcase
        return fs;
    endfunction

    function automatic logic [15:0] lo_data(cmd_e c, logic [7:0] b);
        logic [15:0] d;
        unique case (c)
            CMD_LOAD8S: d = {{8{b[7]}}, b};
            CMD_CLEAR:  d = 16'h0000;
            default:    d = {8'h00, b};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for a byte fetch; flags expiry at TIMEOUT-1.
// TIMEOUT=0 never expires.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reg_byte_loader.sv
// Fetches one or two bytes and drives the FunSel/E/I write sequence
// that builds the value in a 16-bit register.
module reg_byte_loader
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Cmd,
    output logic        ByteReq,
    input  logic        ByteAck,
    input  logic [7:0]  ByteIn,
    output logic [2:0]  FunSel,
    output logic        E,
    output logic [15:0] I,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [7:0]  byte_q, byte_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        e_q, e_d;
    funsel_e     fs_q, fs_d;
    logic [15:0] i_q, i_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        in_fetch;
    logic        expired;

    assign in_fetch = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_ctr (
        .clk_i    (Clock),
        .rst_ni   (Reset),
        .clr_i    (!in_fetch),
        .en_i     (!ByteAck),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        byte_d  = byte_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    cmd_d   = cmd_e'(Cmd);
                    err_d   = 1'b0;
                    state_d = (cmd_e'(Cmd) == CMD_CLEAR) ? ST_WRITE_LO
                                                         : ST_FETCH_LO;
                end
            end
            ST_FETCH_LO, ST_FETCH_HI: begin
                if (ByteAck) begin
                    byte_d  = ByteIn;
                    state_d = (state_q == ST_FETCH_LO) ? ST_WRITE_LO
                                                       : ST_WRITE_HI;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE_LO:
                state_d = (cmd_q == CMD_LOAD16) ? ST_FETCH_HI : ST_DONE;
            ST_WRITE_HI:
                state_d = ST_DONE;
            ST_DONE:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        req_d  = (state_d == ST_FETCH_LO) || (state_d == ST_FETCH_HI);
        e_d    = (state_d == ST_WRITE_LO) || (state_d == ST_WRITE_HI);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        fs_d   = FS_DEC;
        i_d    = 16'h0000;
        if (state_d == ST_WRITE_LO) begin
            fs_d = lo_funsel(cmd_d);
            i_d  = lo_data(cmd_d, byte_d);
        end else if (state_d == ST_WRITE_HI) begin
            fs_d = FS_WRHI;
            i_d  = {8'h00, byte_d};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_LOAD16;
            byte_q  <= 8'h00;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            e_q     <= 1'b0;
            fs_q    <= FS_DEC;
            i_q     <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            req_q   <= req_d;
            e_q     <= e_d;
            fs_q    <= fs_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ByteReq = req_q;
    assign E       = e_q;
    assign FunSel  = fs_q;
    assign I       = i_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_reg_byte_loader.sv
// Scoreboard bench for reg_byte_loader with an attached 16-bit register model.
// Expected writes and completions are queued by stimulus, popped by a monitor.
module tb_reg_byte_loader;

    localparam int unsigned TO = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Cmd = 2'b00;
    logic        ByteAck = 1'b0;
    logic [7:0]  ByteIn = 8'h00;
    logic        ByteReq;
    logic [2:0]  FunSel;
    logic        E;
    logic [15:0] I;
    logic        Busy;
    logic        Done;
    logic        Err;

    always #5 Clock = ~Clock;

    reg_byte_loader #(.TIMEOUT(TO)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Cmd    (Cmd),
        .ByteReq(ByteReq),
        .ByteAck(ByteAck),
        .ByteIn (ByteIn),
        .FunSel (FunSel),
        .E      (E),
        .I      (I),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    typedef struct {
        bit          is_done;
        logic [2:0]  fs;
        logic [15:0] data;
        logic        err;
        int          lat;
        logic [15:0] rv;
    } exp_t;

    exp_t        q[$];
    exp_t        x;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [15:0] reg_m = 16'h0000;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge Clock) cyc <= cyc + 1;

    // Attached 16-bit register: captures on the edge ending an E cycle.
    always @(posedge Clock) begin
        if (E) begin
            case (FunSel)
                3'b000: reg_m <= reg_m - 16'd1;
                3'b001: reg_m <= reg_m + 16'd1;
                3'b010: reg_m <= I;
                3'b011: reg_m <= 16'h0000;
                3'b100: reg_m <= {8'h00, I[7:0]};
                3'b101: reg_m <= {reg_m[15:8], I[7:0]};
                3'b110: reg_m <= {I[7:0], reg_m[7:0]};
                default: reg_m <= {{8{I[7]}}, I[7:0]};
            endcase
        end
    end

    always @(negedge Clock) begin
        if (Reset && (E || Done)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, E, Done}, 32'd0);
            end else begin
                x = q.pop_front();
                if (x.is_done) begin
                    chk("done_pulse", {31'd0, Done}, 32'd1);
                    chk("done_no_we", {31'd0, E}, 32'd0);
                    chk("err", {31'd0, Err}, {31'd0, x.err});
                    chk("latency", cyc - start_cyc, x.lat);
                    chk("reg_value", {16'd0, reg_m}, {16'd0, x.rv});
                end else begin
                    chk("we", {31'd0, E}, 32'd1);
                    chk("funsel", {29'd0, FunSel}, {29'd0, x.fs});
                    chk("wdata", {16'd0, I}, {16'd0, x.data});
                end
            end
        end
    end

    task automatic push_w(logic [2:0] fs, logic [15:0] d);
        exp_t e;
        e.is_done = 1'b0; e.fs = fs; e.data = d;
        e.err = 1'b0; e.lat = 0; e.rv = 16'h0;
        q.push_back(e);
    endtask

    task automatic push_d(logic err, int lat, logic [15:0] rv);
        exp_t e;
        e.is_done = 1'b1; e.fs = 3'b000; e.data = 16'h0;
        e.err = err; e.lat = lat; e.rv = rv;
        q.push_back(e);
    endtask

    task automatic go(logic [1:0] c);
        @(negedge Clock);
        Cmd = c;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        start_cyc = cyc;
        Start = 1'b0;
        Cmd = ~c;
        chk("busy_after_start", {31'd0, Busy}, 32'd1);
        chk("err_clr_on_start", {31'd0, Err}, 32'd0);
        @(negedge Clock);
    endtask

    task automatic fetch(int w, logic [7:0] b);
        int n = 0;
        int held = 0;
        while (ByteReq !== 1'b1 && n < 30) begin
            @(negedge Clock);
            n++;
        end
        chk("req_rise", {31'd0, ByteReq}, 32'd1);
        if (ByteReq === 1'b1) begin
            ByteAck = 1'b0;
            for (int i = 0; i < w; i++) begin
                if (ByteReq === 1'b1) held++;
                @(negedge Clock);
            end
            if (ByteReq === 1'b1) held++;
            ByteAck = 1'b1;
            ByteIn = b;
            @(posedge Clock);
            #1;
            ByteAck = 1'b0;
            ByteIn = 8'h00;
            chk("req_held", held, w + 1);
            chk("req_drop", {31'd0, ByteReq}, 32'd0);
        end
    endtask

    task automatic finish_txn();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge Clock);
            n++;
        end
        chk("drain", q.size(), 0);
        q.delete();
        #1;
        chk("idle_busy", {31'd0, Busy}, 32'd0);
        chk("idle_done", {31'd0, Done}, 32'd0);
        @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_req", {31'd0, ByteReq}, 32'd0);
        chk("rst_e", {31'd0, E}, 32'd0);
        chk("rst_funsel", {29'd0, FunSel}, 32'd0);
        chk("rst_i", {16'd0, I}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_err", {31'd0, Err}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // load16 zero-wait
        push_w(3'b101, 16'h0034);
        push_w(3'b110, 16'h0012);
        push_d(1'b0, 4, 16'h1234);
        go(2'b00);
        fetch(0, 8'h34);
        fetch(0, 8'h12);
        finish_txn();

        // load8 sign-extend
        push_w(3'b111, 16'hFF80);
        push_d(1'b0, 2, 16'hFF80);
        go(2'b10);
        fetch(0, 8'h80);
        finish_txn();

        // load8 zero-extend
        push_w(3'b100, 16'h009C);
        push_d(1'b0, 2, 16'h009C);
        go(2'b01);
        fetch(0, 8'h9C);
        finish_txn();

        // preload 0xBEEF then clear
        push_w(3'b101, 16'h00EF);
        push_w(3'b110, 16'h00BE);
        push_d(1'b0, 4, 16'hBEEF);
        go(2'b00);
        fetch(0, 8'hEF);
        fetch(0, 8'hBE);
        finish_txn();

        push_w(3'b011, 16'h0000);
        push_d(1'b0, 1, 16'h0000);
        go(2'b11);
        for (int i = 0; i < 3; i++) begin
            chk("clear_no_req", {31'd0, ByteReq}, 32'd0);
            @(negedge Clock);
        end
        finish_txn();

        // load16 with 3 wait cycles per byte, Starts while busy
        push_w(3'b101, 16'h0078);
        push_w(3'b110, 16'h0056);
        push_d(1'b0, 10, 16'h5678);
        go(2'b00);
        Start = 1'b1;
        Cmd = 2'b11;
        fetch(3, 8'h78);
        Start = 1'b0;
        fetch(3, 8'h56);
        Start = 1'b1;
        Cmd = 2'b11;
        finish_txn();
        Start = 1'b0;

        // high byte never acked
        push_w(3'b101, 16'h00AA);
        push_d(1'b1, 6, 16'h56AA);
        go(2'b00);
        fetch(0, 8'hAA);
        finish_txn();
        repeat (2) @(negedge Clock);
        chk("err_held", {31'd0, Err}, 32'd1);

        // next Start clears Err
        push_w(3'b111, 16'h007F);
        push_d(1'b0, 2, 16'h007F);
        go(2'b10);
        fetch(0, 8'h7F);
        finish_txn();

        // low byte never acked
        push_d(1'b1, 4, 16'h007F);
        go(2'b01);
        finish_txn();

        // reset during WRITE_HI
        push_w(3'b101, 16'h0011);
        go(2'b00);
        fetch(0, 8'h11);
        fetch(0, 8'h22);
        chk("we_in_write_hi", {31'd0, E}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("arst_e", {31'd0, E}, 32'd0);
        chk("arst_funsel", {29'd0, FunSel}, 32'd0);
        chk("arst_i", {16'd0, I}, 32'd0);
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_req", {31'd0, ByteReq}, 32'd0);
        chk("arst_done", {31'd0, Done}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("arst_reg_kept", {16'd0, reg_m}, 32'h0011);
        chk("arst_queue", q.size(), 0);
        chk("arst_idle", {31'd0, Busy}, 32'd0);
        @(negedge Clock);

        // recovery after reset
        push_w(3'b100, 16'h0001);
        push_d(1'b0, 2, 16'h0001);
        go(2'b01);
        fetch(0, 8'h01);
        finish_txn();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_byte_loader.md
# reg_byte_loader

Initiator side of the 16-bit register's FunSel/E/I write interface. Sits between the 8-bit memory data path and one 16-bit register. On a command, it fetches one or two bytes through a req/ack handshake and emits the exact FunSel/E/I write sequence needed to build the value in the register, then signals completion. It also issues single-cycle clear writes.

## Interface
- TIMEOUT, 16: maximum cycles ByteReq may wait for ByteAck; 0 disables the timeout
- Clock  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  command strobe, sampled only in IDLE
- Cmd  input  2  00 load16 little-endian, 01 load8 zero-extend, 10 load8 sign-extend, 11 clear
- ByteReq  output  1  byte fetch request
- ByteAck  input  1  byte valid, sampled on the rising edge
- ByteIn  input  8  fetched byte, valid when ByteAck=1
- FunSel  output  3  register function select
- E  output  1  register write enable, one cycle per write
- I  output  16  register data input
- Busy  output  1  high outside IDLE
- Done  output  1  one-cycle completion pulse
- Err  output  1  set with Done when a fetch timed out; held until the next Start

## Operation
- States: IDLE, FETCH_LO, WRITE_LO, FETCH_HI, WRITE_HI, DONE.
- IDLE + Start=1:
  - Cmd 00/01/10 -> FETCH_LO
  - Cmd 11 -> WRITE_LO with the clear write
  - Err is cleared on this transition.
- FETCH_LO / FETCH_HI: ByteReq=1. On an edge with ByteAck=1, ByteIn is latched into an internal byte register and the FSM moves to the matching WRITE state.
- WRITE_LO drives E=1 for exactly one cycle. FunSel and I by command:
  - load16: FunSel=101, I={8'h00, byte}
  - load8 zero-extend: FunSel=100, I={8'h00, byte}
  - load8 sign-extend: FunSel=111, I={{8{byte[7]}}, byte}
  - clear: FunSel=011, I=16'h0000
- After WRITE_LO: load16 -> FETCH_HI; all other commands -> DONE.
- WRITE_HI: E=1, FunSel=110, I={8'h00, byte}, then -> DONE.
- DONE: Done=1 for one cycle, then -> IDLE.
- Timeout:
  - A counter starts at 0 on entry to either FETCH state and increments each cycle ByteAck=0.
  - When it reaches TIMEOUT-1 with no ack, the FSM goes to DONE with Err=1 and performs no further writes.
  - An already-written low byte stays in the register.
- Start while Busy is ignored. Cmd is latched at Start.
- Outside WRITE states: E=0, FunSel=000, I=16'h0000. All outputs are registered.

## Timing
- Reset (async assert, sync release): state IDLE; ByteReq=0, E=0, FunSel=000, I=0, Busy=0, Done=0, Err=0; counter and byte register 0.
- Reset asserted mid-operation aborts immediately. E drops asynchronously, so no partial write occurs after reset.
- ByteReq rises the cycle after the Start edge and stays high until the edge that samples ByteAck=1. It is low in the following cycle. An ack while ByteReq=0 is ignored.
- With zero-wait ack (ack in the first ByteReq cycle), Done is high in the cycle after edge:
  - load16: start+4
  - load8: start+2
  - clear: start+1
- Each wait cycle adds 1 per fetch.
- The register captures each write on the edge that ends the E=1 cycle. FunSel 101/110 leave the other byte untouched, so load16 needs no prior clear.
- Busy is high from the cycle after Start through the Done cycle inclusive. A Start coinciding with the Done cycle is ignored; the earliest accepted Start is the first IDLE cycle.

## Structure
- Shared package/header reg_ctrl_pkg:
  - FunSel encodings: DEC=000, INC=001, LOAD=010, CLR=011, LOADLZ=100, WRLO=101, WRHI=110, LOADSX=111
  - Cmd encodings
  - State encodings
- The 16-bit register and this block share the FunSel encodings.
- One sub-module, fetch_timeout_ctr: counter with clear, enable, and an expired flag, parameterized by TIMEOUT.
- The FSM and output registers stay in the top module.

## Test plan
- load16, zero-wait ack, bytes 0x34 then 0x12:
  - E pulses with FunSel 101/I=0x0034, then 110/I=0x0012.
  - Attached register reads 0x1234.
  - Done at start+4.
- load8 sign-extend, byte 0x80 -> single write, FunSel 111, I=0xFF80; register=0xFF80; Done at start+2.
- clear with register preloaded 0xBEEF -> one write FunSel 011; register=0x0000; Done at start+1; ByteReq never asserted.
- load16 with 3 wait cycles per byte -> ByteReq held 4 cycles each; Done at start+10; register = assembled value.
- TIMEOUT=4, low byte acked 0xAA, high byte never acked -> Done+Err after 4 FETCH_HI cycles; register low byte=0xAA, high byte unchanged.
- Reset pulled low during WRITE_HI cycle; Start during Busy -> all outputs 0 at once, register not written; ignored Start produces no second sequence.
